// File: rtl/missile_launcher.sv
// ============================================================================
// Module      : missile_launcher
// Description : Fire-control stage for the missile movement blocks. Turns the
//               fire button into single-cycle, one-hot launch pulses, keeps a
//               frame-based cooldown between shots, and never launches into a
//               slot that is in flight or still waiting for its movement block
//               to report active.
//               Optional feature macro: MISSILE_LAUNCHER_AUTO_FIRE_EN
//               (defined: the button level is the request, so a held button
//               re-fires after every cooldown; undefined: rising edges only).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module missile_launcher #(
    parameter int NUM_MISSILES    = 4,
    parameter int COOLDOWN_FRAMES = 8,
    parameter int PENDING_TIMEOUT = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    startOfFrame,
    input  logic                    fire_button,
    input  logic [NUM_MISSILES-1:0] missile_active,
    output logic [NUM_MISSILES-1:0] shooting_pulse,
    output logic                    cooldown_active,
    output logic [15:0]             shots_fired
);

    localparam int         PTR_W        = (NUM_MISSILES > 1) ? $clog2(NUM_MISSILES) : 1;
    localparam logic [7:0] CD_LOAD      = 8'(COOLDOWN_FRAMES);
    localparam logic [1:0] TIMEOUT_AGE  = 2'(PENDING_TIMEOUT);
    localparam logic [PTR_W-1:0] LAST_SLOT = PTR_W'(NUM_MISSILES - 1);

    typedef enum logic [1:0] {
        ST_READY    = 2'd0,
        ST_FIRE     = 2'd1,
        ST_COOLDOWN = 2'd2
    } state_t;

    state_t                           state_q, state_d;
    logic [PTR_W-1:0]                 rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]                 slot_q, slot_d;
    logic [7:0]                       cd_cnt_q, cd_cnt_d;
    logic [NUM_MISSILES-1:0]          pending_q, pending_d;
    logic [NUM_MISSILES-1:0][1:0]     age_q, age_d;
    logic [NUM_MISSILES-1:0]          pulse_q, pulse_d;
    logic [15:0]                      shots_q, shots_d;
    logic                             cd_active_q, cd_active_d;
    logic                             fire_prev_q, fire_prev_d;

    logic                             req;
    logic [NUM_MISSILES-1:0]          free;
    logic                             found_hi, found_lo, found;
    logic [PTR_W-1:0]                 sel_hi, sel_lo, sel;

    // Launch request: level in auto-fire builds, rising edge otherwise
    always_comb begin
        fire_prev_d = fire_button;
`ifdef MISSILE_LAUNCHER_AUTO_FIRE_EN
        req = fire_button;
`else
        req = fire_button & ~fire_prev_q;
`endif
    end

    // Round-robin pick: first free slot at or above rr_ptr, else first free below it
    always_comb begin
        free     = ~missile_active & ~pending_q;
        found_hi = 1'b0;
        found_lo = 1'b0;
        sel_hi   = '0;
        sel_lo   = '0;
        for (int j = 0; j < NUM_MISSILES; j++) begin
            if (free[j] && (j >= int'(rr_ptr_q)) && !found_hi) begin
                found_hi = 1'b1;
                sel_hi   = PTR_W'(j);
            end
            if (free[j] && (j < int'(rr_ptr_q)) && !found_lo) begin
                found_lo = 1'b1;
                sel_lo   = PTR_W'(j);
            end
        end
        found = found_hi | found_lo;
        sel   = found_hi ? sel_hi : sel_lo;
    end

    // Next-state, slot bookkeeping and launch pulse generation
    always_comb begin
        state_d   = state_q;
        slot_d    = slot_q;
        rr_ptr_d  = rr_ptr_q;
        cd_cnt_d  = cd_cnt_q;
        pending_d = pending_q;
        age_d     = age_q;
        pulse_d   = '0;
        shots_d   = shots_q;

        // A reservation ends when the movement block reports active, or after
        // the timeout frame count if it never does.
        for (int j = 0; j < NUM_MISSILES; j++) begin
            if (pending_q[j]) begin
                if (missile_active[j]) begin
                    pending_d[j] = 1'b0;
                    age_d[j]     = 2'd0;
                end else if (startOfFrame) begin
                    if ((age_q[j] + 2'd1) == TIMEOUT_AGE) begin
                        pending_d[j] = 1'b0;
                        age_d[j]     = 2'd0;
                    end else begin
                        age_d[j] = age_q[j] + 2'd1;
                    end
                end
            end
        end

        case (state_q)
            ST_READY: begin
                if (req && found) begin
                    slot_d  = sel;
                    state_d = ST_FIRE;
                end
            end
            ST_FIRE: begin
                // A pulse coinciding with the frame strobe would be ignored
                // downstream, so hold here until the strobe has passed.
                if (!startOfFrame) begin
                    for (int j = 0; j < NUM_MISSILES; j++) begin
                        if (slot_q == PTR_W'(j)) begin
                            pulse_d[j]   = 1'b1;
                            pending_d[j] = 1'b1;
                            age_d[j]     = 2'd0;
                        end
                    end
                    shots_d  = shots_q + 16'd1;
                    rr_ptr_d = (slot_q == LAST_SLOT) ? '0 : slot_q + PTR_W'(1);
                    if (COOLDOWN_FRAMES == 0) begin
                        state_d = ST_READY;
                    end else begin
                        state_d  = ST_COOLDOWN;
                        cd_cnt_d = CD_LOAD;
                    end
                end
            end
            ST_COOLDOWN: begin
                if (startOfFrame) begin
                    if (cd_cnt_q <= 8'd1) begin
                        cd_cnt_d = 8'd0;
                        state_d  = ST_READY;
                    end else begin
                        cd_cnt_d = cd_cnt_q - 8'd1;
                    end
                end
            end
            default: begin
                state_d = ST_READY;
            end
        endcase

        // Game paused: abandon everything in flight except the shot count and
        // the round-robin position.
        if (!enable) begin
            state_d   = ST_READY;
            cd_cnt_d  = 8'd0;
            pending_d = '0;
            age_d     = '0;
            pulse_d   = '0;
            shots_d   = shots_q;
            rr_ptr_d  = rr_ptr_q;
        end

        cd_active_d = (state_d == ST_COOLDOWN);
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_READY;
            slot_q      <= '0;
            rr_ptr_q    <= '0;
            cd_cnt_q    <= 8'd0;
            pending_q   <= '0;
            age_q       <= '0;
            pulse_q     <= '0;
            shots_q     <= 16'd0;
            cd_active_q <= 1'b0;
            fire_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            slot_q      <= slot_d;
            rr_ptr_q    <= rr_ptr_d;
            cd_cnt_q    <= cd_cnt_d;
            pending_q   <= pending_d;
            age_q       <= age_d;
            pulse_q     <= pulse_d;
            shots_q     <= shots_d;
            cd_active_q <= cd_active_d;
            fire_prev_q <= fire_prev_d;
        end
    end

    assign shooting_pulse  = pulse_q;
    assign cooldown_active = cd_active_q;
    assign shots_fired     = shots_q;

endmodule

`default_nettype wire
